uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_transmitter.sv | 118 +++++++++++
 tb/tb_uart_transmitter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame length and the baud divisor,
// so the transmitter and receiver derive the identical bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_FRAME_BITS = 10;

    // Never returns less than 1 so degenerate sizes still yield a legal vector.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with registered full/empty flags; read data is valid whenever !empty.
// A push while full is dropped even if a pop happens on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed through a ready/valid byte FIFO; start bit appears two
// edges after a byte is accepted while idle. Ready drops while the FIFO is full.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W = clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    uart_state_t                state;
    uart_state_t                state_next;
    logic [CNT_W-1:0]           baud_cnt;
    logic [2:0]                 bit_idx;
    logic [UART_FRAME_BITS-1:0] shifter;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [7:0]                 fifo_data;
    logic                       tick;
    logic                       load;
    logic                       shift;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (data_in_valid),
        .push_data (data_in),
        .pop       (load),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_in_ready = !fifo_full;
    assign tick          = (baud_cnt == CNT_LAST);
    assign busy          = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STOP reloads straight into START so consecutive frames have no idle gap.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    shift      = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        state_next = START;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= '1;
            serial_out <= 1'b1;
        end else begin
            serial_out <= (state == IDLE) ? 1'b1 : shifter[0];
            if (load) begin
                shifter  <= {1'b1, fifo_data, 1'b0};
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (state != IDLE) begin
                baud_cnt <= tick ? '0 : baud_cnt + CNT_W'(1);
                if (shift) shifter <= {1'b1, shifter[UART_FRAME_BITS-1:1]};
                if (shift && state == DATA) bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench: a fast instance (8 cycles/bit) and a default-parameter instance,
// with a line decoder and a frame-start timing model.
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int F_CLK  = 800;
    localparam int F_BAUD = 100;
    localparam int F_SET  = F_CLK / F_BAUD;
    localparam int D_SET  = 50_000_000 / 115_200;
    localparam int FRAME  = 10;

    logic       clk;
    logic       rst_n;
    logic [7:0] f_data, d_data;
    logic       f_valid, d_valid;
    logic       f_ready, d_ready;
    logic       f_so, d_so;
    logic       f_busy, d_busy;

    int cyc;
    int n_chk, n_bad;
    int a0, a_f, s_f, errs, first_stall;
    int accs [8];
    logic [7:0] rb;
    logic       rstop;
    int         rst;
    bit         rbad, rto;
    logic [7:0] exp_q [$];
    int         acc_q [$];

    uart_transmitter #(
        .CLOCK_FREQ (F_CLK),
        .BAUD_RATE  (F_BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (f_data),
        .data_in_valid (f_valid),
        .data_in_ready (f_ready),
        .serial_out    (f_so),
        .busy          (f_busy)
    );

    uart_transmitter dut_def (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (d_data),
        .data_in_valid (d_valid),
        .data_in_ready (d_ready),
        .serial_out    (d_so),
        .busy          (d_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? d_so : f_so;
    endfunction

    // Caller is at a negedge; returns at the negedge after the acceptance edge.
    task automatic push_byte(input logic [7:0] b, input int budget, output int acc, output int stalls);
        f_data  = b;
        f_valid = 1'b1;
        stalls  = 0;
        acc     = -1;
        while (!f_ready && stalls < budget) begin
            @(negedge clk);
            stalls++;
        end
        if (!f_ready) begin
            check_eq("push_timeout", f_ready, 1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        exp_q.push_back(b);
        acc_q.push_back(acc);
    endtask

    // Decode one frame sampled once per cycle; every cycle of each bit must match.
    task automatic rx_frame(input bit sel, input int set, input int budget,
                            output logic [7:0] b, output logic stop, output int start,
                            output bit bad, output bit to);
        logic [FRAME-1:0] bits;
        int n;
        b = '0; stop = 1'b0; start = -1; bad = 1'b0; to = 1'b0; bits = '0; n = 0;
        while (line_of(sel) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (line_of(sel) !== 1'b0) begin
            to = 1'b1;
            return;
        end
        start = cyc;
        for (int k = 1; k < FRAME * set; k++) begin
            @(negedge clk);
            if (k % set == 0) bits[k / set] = line_of(sel);
            else if (line_of(sel) !== bits[k / set]) bad = 1'b1;
        end
        b    = bits[8:1];
        stop = bits[9];
    endtask

    // Model: a frame starts 2 cycles after acceptance, or right after the previous frame.
    task automatic rx_check(input string tag, input int nframes, input int budget);
        int prev_start;
        prev_start = -1_000_000;
        for (int i = 0; i < nframes; i++) begin
            logic [7:0] b, eb;
            logic       stop;
            int         st, ea, model_start;
            bit         bad, to;
            rx_frame(1'b0, F_SET, budget, b, stop, st, bad, to);
            check_eq($sformatf("%s_timeout%0d", tag, i), to, 0);
            if (to) return;
            if (exp_q.size() == 0) begin
                check_eq($sformatf("%s_unexpected%0d", tag, i), exp_q.size(), 1);
                return;
            end
            eb = exp_q.pop_front();
            ea = acc_q.pop_front();
            model_start = (ea + 2 > prev_start + FRAME * F_SET) ? ea + 2 : prev_start + FRAME * F_SET;
            check_eq($sformatf("%s_data%0d", tag, i), b, eb);
            check_eq($sformatf("%s_width%0d", tag, i), bad, 0);
            check_eq($sformatf("%s_stop%0d", tag, i), stop, 1);
            check_eq($sformatf("%s_start%0d", tag, i), st, model_start);
            prev_start = model_start;
        end
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        rst_n = 1'b0;
        f_valid = 1'b0; d_valid = 1'b0; f_data = '0; d_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_so", f_so, 1);
        check_eq("rst_ready", f_ready, 1);
        check_eq("rst_busy", f_busy, 0);
        check_eq("rst_def_so", d_so, 1);
        rst_n = 1'b1;
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (f_so !== 1'b1 || f_ready !== 1'b1 || f_busy !== 1'b0 ||
                d_so !== 1'b1 || d_ready !== 1'b1 || d_busy !== 1'b0) errs++;
        end
        check_eq("idle_1000", errs, 0);

        push_byte(8'hA5, 10, a_f, s_f);
        f_valid = 1'b0;
        check_eq("single_busy", f_busy, 1);
        rx_check("single", 1, 50);
        check_eq("single_busy_end", f_busy, 0);
        @(negedge clk);
        check_eq("single_idle_line", f_so, 1);

        push_byte(8'h00, 10, a_f, s_f);
        push_byte(8'hFF, 10, a_f, s_f);
        f_valid = 1'b0;
        rx_check("b2b", 2, 50);
        repeat (5) @(negedge clk);

        fork
            begin
                first_stall = -1;
                for (int i = 0; i < 8; i++) begin
                    push_byte(8'(i + 1), 2000, a_f, s_f);
                    if (s_f > 0 && first_stall < 0) first_stall = i;
                    accs[i] = a_f;
                end
                f_valid = 1'b0;
                check_eq("full_accepted_before_stall", first_stall, 5);
                check_eq("full_ready_return", accs[5] - accs[0], FRAME * F_SET + 2);
            end
            rx_check("full", 8, 3000);
        join
        repeat (5) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 120)) @(negedge clk);
                    push_byte(8'($urandom), 2000, a_f, s_f);
                    f_valid = 1'b0;
                end
            end
            rx_check("rand", 10, 3000);
        join
        repeat (5) @(negedge clk);

        // Reset during a low start bit must raise the line before any clock edge.
        push_byte(8'h00, 10, a0, s_f);
        f_valid = 1'b0;
        repeat (a0 + 5 - cyc) @(negedge clk);
        check_eq("rst_start_low", f_so, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_line", f_so, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(negedge clk);

        push_byte(8'h5A, 10, a0, s_f);
        push_byte(8'h11, 10, a_f, s_f);
        push_byte(8'h22, 10, a_f, s_f);
        f_valid = 1'b0;
        repeat (a0 + 2 + 4 * F_SET + 3 - cyc) @(negedge clk);
        rb = 8'h5A;
        check_eq("rst_bit3_line", f_so, rb[3]);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_line", f_so, 1);
        check_eq("rst_mid_busy", f_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        errs = 0;
        repeat (300) begin
            @(negedge clk);
            if (f_so !== 1'b1 || f_busy !== 1'b0 || f_ready !== 1'b1) errs++;
        end
        check_eq("rst_no_frames", errs, 0);

        check_eq("def_ready", d_ready, 1);
        d_data  = 8'h55;
        d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a0 = cyc;
        d_valid = 1'b0;
        rx_frame(1'b1, D_SET, 100, rb, rstop, rst, rbad, rto);
        check_eq("def_timeout", rto, 0);
        check_eq("def_data", rb, 8'h55);
        check_eq("def_width", rbad, 0);
        check_eq("def_stop", rstop, 1);
        check_eq("def_start", rst, a0 + 2);
        check_eq("def_busy_end", d_busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
